// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: one-hot opcodes, FSM state encoding and
// the opcode legality check.
package alu_seq_pkg;

    localparam logic [4:0] OP_NAND = 5'b00001;
    localparam logic [4:0] OP_XOR  = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [4:0] s);
        return (s != 5'd0) && ((s & (s - 5'd1)) == 5'd0);
    endfunction

endpackage

// File: rtl/alu_seq_booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier, one step per clock.
// done marks the cycle whose coming edge performs the final step; product
// is the post-step value, so the caller can register it on that edge.
module booth_mul_seq #(
    parameter int NR_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NR_BITS-1:0]     a,
    input  logic [NR_BITS-1:0]     b,
    output logic                   busy,
    output logic                   done,
    output logic [2*NR_BITS-1:0]   product
);
    localparam int CW = $clog2(NR_BITS + 1);

    logic [NR_BITS:0]   acc;
    logic [NR_BITS:0]   mcand;
    logic [NR_BITS-1:0] q;
    logic               q_m1;
    logic [CW-1:0]      cnt;

    logic [NR_BITS:0]   sum;
    logic [NR_BITS:0]   acc_nx;
    logic [NR_BITS-1:0] q_nx;

    // Accumulator is one bit wider so the most-negative multiplicand is exact.
    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b10:   sum = acc - mcand;
            2'b01:   sum = acc + mcand;
            default: sum = acc;
        endcase
        acc_nx = {sum[NR_BITS], sum[NR_BITS:1]};
        q_nx   = {sum[0], q[NR_BITS-1:1]};
    end

    assign product = {acc_nx[NR_BITS-1:0], q_nx};
    assign done    = busy && (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            acc   <= '0;
            mcand <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            acc   <= '0;
            mcand <= {a[NR_BITS-1], a};
            q     <= b;
            q_m1  <= 1'b0;
            cnt   <= CW'(NR_BITS);
        end else if (busy) begin
            acc  <= acc_nx;
            q    <= q_nx;
            q_m1 <= q[0];
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake and sequential Booth multiply.
// Define ALU_SEQ_CARRY_EN to report ADD carry / SUB borrow in out[NR_BITS].
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NR_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             sel,
    input  logic [NR_BITS-1:0]     in0,
    input  logic [NR_BITS-1:0]     in1,
    output logic [2*NR_BITS-1:0]   out,
    output logic                   err,
    output logic                   out_valid,
    input  logic                   out_ready
);
    state_t                 state;
    logic                   mul_start;
    logic                   mul_busy;
    logic                   mul_done;
    logic [2*NR_BITS-1:0]   mul_product;
    logic [2*NR_BITS-1:0]   alu_res;

    assign in_ready  = (state == S_IDLE) && !reset;
    assign mul_start = in_valid && in_ready && (sel == OP_MUL);

`ifdef ALU_SEQ_CARRY_EN
    logic [NR_BITS:0] add_r;
    logic [NR_BITS:0] sub_r;
    assign add_r = {1'b0, in0} + {1'b0, in1};
    assign sub_r = {1'b0, in0} - {1'b0, in1};
`else
    logic [NR_BITS-1:0] add_r;
    logic [NR_BITS-1:0] sub_r;
    assign add_r = in0 + in1;
    assign sub_r = in0 - in1;
`endif

    always_comb begin
        alu_res = '0;
        case (sel)
            OP_NAND: alu_res = {{NR_BITS{1'b0}}, ~(in0 & in1)};
            OP_XOR:  alu_res = {{NR_BITS{1'b0}}, in0 ^ in1};
`ifdef ALU_SEQ_CARRY_EN
            OP_ADD:  alu_res = {{(NR_BITS-1){1'b0}}, add_r};
            OP_SUB:  alu_res = {{(NR_BITS-1){1'b0}}, sub_r};
`else
            OP_ADD:  alu_res = {{NR_BITS{1'b0}}, add_r};
            OP_SUB:  alu_res = {{NR_BITS{1'b0}}, sub_r};
`endif
            default: alu_res = '0;
        endcase
    end

    booth_mul_seq #(.NR_BITS(NR_BITS)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (in0),
        .b       (in1),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            out       <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!is_onehot(sel)) begin
                            out       <= '0;
                            err       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else if (sel == OP_MUL) begin
                            err   <= 1'b0;
                            state <= S_MUL;
                        end else begin
                            out       <= alu_res;
                            err       <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        out       <= mul_product;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (!mul_busy) begin
                        // multiplier lost its operation; never wait forever
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with NR_BITS=4.
module tb_alu_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] sel;
    logic [3:0] in0;
    logic [3:0] in1;
    logic [7:0] out;
    logic       err;
    logic       out_valid;
    logic       out_ready;

    int checks = 0;
    int errors = 0;
    int lat;
    int seen;

    alu_seq #(.NR_BITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .in0       (in0),
        .in1       (in1),
        .out       (out),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation in IDLE, then count edges until out_valid.
    task automatic issue(input logic [4:0] s, input logic [3:0] a, input logic [3:0] b,
                         output int l);
        in_valid = 1'b1;
        sel = s;
        in0 = a;
        in1 = b;
        tick();
        in_valid = 1'b0;
        sel = 5'b00100;
        in0 = 4'h5;
        in1 = 4'h3;
        l = -1;
        for (int n = 1; n <= 20; n++) begin
            if (out_valid) begin
                l = n;
                break;
            end
            tick();
        end
    endtask

    logic [3:0] ma [4];
    logic [3:0] mb [4];
    logic [7:0] me [4];

    initial begin
        ma = '{4'h8, 4'h2, 4'hF, 4'hF};
        mb = '{4'h8, 4'hF, 4'hA, 4'h5};
        me = '{8'h40, 8'hFE, 8'h06, 8'hFB};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sel = 5'd0;
        in0 = 4'd0;
        in1 = 4'd0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_out", {24'd0, out}, 32'h00);
        check("post_rst_err", {31'd0, err}, 32'd0);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        issue(5'b00001, 4'd6, 4'd9, lat);
        check("nand_lat", lat, 32'd1);
        check("nand_out", {24'd0, out}, 32'h0F);
        check("nand_err", {31'd0, err}, 32'd0);
        tick();
        check("nand_valid_one_cycle", {31'd0, out_valid}, 32'd0);
        check("nand_back_idle", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            issue(5'b10000, ma[i], mb[i], lat);
            check($sformatf("mul%0d_lat", i), lat, 32'd5);
            check($sformatf("mul%0d_out", i), {24'd0, out}, {24'd0, me[i]});
            check($sformatf("mul%0d_err", i), {31'd0, err}, 32'd0);
            tick();
        end

        issue(5'b01000, 4'd5, 4'd7, lat);
        check("sub_lat", lat, 32'd1);
`ifdef ALU_SEQ_CARRY_EN
        check("sub_out", {24'd0, out}, 32'h1E);
`else
        check("sub_out", {24'd0, out}, 32'h0E);
`endif
        tick();
        issue(5'b00100, 4'd9, 4'd9, lat);
`ifdef ALU_SEQ_CARRY_EN
        check("add_out", {24'd0, out}, 32'h12);
`else
        check("add_out", {24'd0, out}, 32'h02);
`endif
        tick();

        out_ready = 1'b0;
        issue(5'b10000, 4'h4, 4'hC, lat);
        check("stall_lat", lat, 32'd5);
        check("stall_out0", {24'd0, out}, 32'hF0);
        in_valid = 1'b1;
        sel = 5'b00001;
        in0 = 4'd6;
        in1 = 4'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_out", i), {24'd0, out}, 32'hF0);
            check($sformatf("stall%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();
        check("release_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        check("release_out_kept", {24'd0, out}, 32'hF0);

        issue(5'b00011, 4'd3, 4'd7, lat);
        check("multihot_lat", lat, 32'd1);
        check("multihot_out", {24'd0, out}, 32'h00);
        check("multihot_err", {31'd0, err}, 32'd1);
        tick();
        issue(5'b00000, 4'd3, 4'd7, lat);
        check("zero_sel_lat", lat, 32'd1);
        check("zero_sel_out", {24'd0, out}, 32'h00);
        check("zero_sel_err", {31'd0, err}, 32'd1);
        tick();
        issue(5'b00010, 4'd3, 4'd7, lat);
        check("xor_out", {24'd0, out}, 32'h04);
        check("xor_err", {31'd0, err}, 32'd0);
        tick();

        in_valid = 1'b1;
        sel = 5'b10000;
        in0 = 4'd4;
        in1 = 4'd4;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("abort_out", {24'd0, out}, 32'h00);
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 32'd0);
        issue(5'b00100, 4'd6, 4'd6, lat);
        check("post_abort_add_lat", lat, 32'd1);
        check("post_abort_add_out", {24'd0, out}, 32'h0C);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the combinational `alu`. It keeps the one-hot opcode set (NAND, XOR, ADD, SUB, MUL) and the double-width result. It adds a valid/ready handshake on both sides, a registered result, an illegal-opcode error flag, and a sequential radix-2 Booth signed multiplier in place of the combinational product. It sits between the register file/decoder and writeback, and accepts one operation at a time.

## Interface
- `NR_BITS`, default 4: operand width; result width is 2*NR_BITS; minimum 2.
- `clk`  input  1: single clock, all state updates on rising edge.
- `reset`  input  1: synchronous, active-high.
- `in_valid`  input  1: operation request.
- `in_ready`  output  1: block can accept an operation.
- `sel`  input  5: one-hot opcode. 1=NAND, 2=XOR, 4=ADD, 8=SUB, 16=MUL.
- `in0`, `in1`  input  NR_BITS each: operands A and B, two's complement for MUL.
- `out`  output  2*NR_BITS: registered result.
- `err`  output  1: registered; 1 when the accepted `sel` was not exactly one-hot.
- `out_valid`  output  1: `out`/`err` hold a result not yet consumed.
- `out_ready`  input  1: consumer accepts the result.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - MUL: Booth iterations in progress.
  - DONE: `out_valid`=1.
- IDLE, accept (`in_valid`&&`in_ready`):
  - Non-MUL legal op: compute and register `out`, then go to DONE.
  - Illegal `sel` (zero or multi-hot): `out`=0, `err`=1, go to DONE.
  - MUL: load multiplicand, multiplier, Q-1=0 and counter=NR_BITS, then go to MUL.
- NAND/XOR: `out`={NR_BITS zeros, bitwise result}.
- ADD/SUB: low NR_BITS of the result, modulo 2^NR_BITS; the upper half is zero unless the configuration macro is defined.
- MUL:
  - Signed Booth radix-2. The accumulator is NR_BITS+1 bits with sign extension, so the most-negative multiplicand is exact.
  - One step per cycle: add/subtract per {Q0,Q-1}, then arithmetic right shift of {Acc,Q,Q-1}.
  - After NR_BITS steps: `out`={Acc[NR_BITS-1:0],Q}, which is the full signed 2*NR_BITS product. Go to DONE.
- DONE: `out`, `err`, `out_valid` held stable until `out_ready`=1. Then go to IDLE with `out_valid`=0; `out` keeps its last value.
- `in_valid` outside IDLE is ignored; `sel`/`in0`/`in1` are sampled only at acceptance.
- No overlap: a new operation cannot be accepted in the same cycle the result is consumed.

## Timing
- Reset values: state IDLE, `out`=0, `err`=0, `out_valid`=0. `in_ready`=0 while `reset` is high and 1 in the first cycle after it.
- Latency, counted from accepting edge to `out_valid` high:
  - 1 cycle for NAND/XOR/ADD/SUB/illegal.
  - NR_BITS+1 cycles for MUL: one load edge plus NR_BITS step edges.
- Throughput: at most one operation per latency+1 cycles when `out_ready` is held high.
- `in_ready` is combinational from state only (state==IDLE && !reset). It does not depend on `in_valid`.
- Reset during MUL or DONE aborts the operation on that edge. The partial product is discarded and no `out_valid` is produced.
- Reset has priority over any simultaneous handshake.

## Configuration
- `ALU_SEQ_CARRY_EN` defined:
  - ADD: `out[NR_BITS]`=unsigned carry-out.
  - SUB: `out[NR_BITS]`=borrow (A<B unsigned).
  - Bits above NR_BITS stay zero.
- Not defined: the ADD/SUB upper half is all zero, bit-compatible with `alu`.

## Structure
- `alu_seq_pkg`: opcode constants OP_NAND..OP_MUL (5-bit one-hot), FSM state encoding (IDLE/MUL/DONE), and a function that checks one-hot legality.
- Sub-module `booth_mul_seq`: owns the Acc/Q/Q-1/counter registers. Interface is `start`, operands, `busy`, `done` pulse, and a 2*NR_BITS `product`.
- `alu_seq` contains the FSM, logic/add/sub datapath, and result register.

## Test plan
All scenarios use NR_BITS=4.
- NAND in0=6, in1=9, `out_ready`=1 → `out`=0x0F, `err`=0, `out_valid` high 1 cycle after accept, and for exactly 1 cycle.
- MUL sequence (-8,-8), (2,-1), (-1,-6), (-1,5) → 0x40, 0xFE, 0x06, 0xFB. Each has `out_valid` exactly 5 cycles after accept.
- SUB 5,7 with the macro off → 0x0E. With `ALU_SEQ_CARRY_EN` defined: SUB 5,7 → 0x1E, and ADD 9,9 → 0x12.
- MUL 4,-4 with `out_ready` low for 3 cycles after `out_valid` → `out`=0xF0 stable and `in_ready`=0. A concurrent `in_valid` NAND is ignored. Raising `out_ready` → IDLE the next cycle.
- `sel`=5'b00011 or 5'b00000 with in0=3, in1=7 → `out`=0x00, `err`=1, 1-cycle latency. A following legal XOR 3,7 → 0x04, `err`=0.
- Reset asserted on the 2nd Booth step of MUL 4,4 → next cycle state IDLE, `out`=0, `out_valid`=0. A subsequent ADD 6,6 → 0x0C.
